// File: rtl/xc_malu_pkg.sv
// Shared definitions for the xc_malu issue/retire wrapper: op and pack-width
// one-hot encodings, FSM state encoding, the operand payload and the op-legality check.
package xc_malu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 7;
  localparam int unsigned PW_W  = 5;
  localparam int unsigned CNT_W = 16;

  // Bit positions within the one-hot op vector.
  localparam int unsigned OP_MUL  = 0;
  localparam int unsigned OP_PMUL = 1;
  localparam int unsigned OP_DIV  = 2;
  localparam int unsigned OP_REM  = 3;
  localparam int unsigned OP_MACC = 4;
  localparam int unsigned OP_MADD = 5;
  localparam int unsigned OP_MSUB = 6;

  localparam logic [PW_W-1:0] PW_32 = 5'b00001;
  localparam logic [PW_W-1:0] PW_16 = 5'b00010;
  localparam logic [PW_W-1:0] PW_8  = 5'b00100;
  localparam logic [PW_W-1:0] PW_4  = 5'b01000;
  localparam logic [PW_W-1:0] PW_2  = 5'b10000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_DONE = ST_DONE
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] rs3;
    logic [OP_W-1:0] insn;
    logic [PW_W-1:0] pw;
    logic            lhs_sign;
    logic            rhs_sign;
    logic            drem_unsigned;
    logic            carryless;
  } malu_req_t;

  // An op is legal only when exactly one bit is set.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op != '0) && ((op & (op - OP_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/xc_malu_issue.sv
// Issue/retire wrapper around xc_malu: single outstanding op, back-to-back issue from DONE.
// Optional macro XC_MALU_ISSUE_CYCLE_COUNT_EN adds out_cycles (BUSY cycles per result).
module xc_malu_issue
  import xc_malu_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_kill,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_rs3,
  input  logic [OP_W-1:0]  in_op,
  input  logic [PW_W-1:0]  in_pw,
  input  logic             in_lhs_sign,
  input  logic             in_rhs_sign,
  input  logic             in_drem_unsigned,
  input  logic             in_carryless,
  input  logic [TAG_W-1:0] in_tag,
  output logic [XLEN-1:0]  malu_rs1,
  output logic [XLEN-1:0]  malu_rs2,
  output logic [XLEN-1:0]  malu_rs3,
  output logic [OP_W-1:0]  malu_insn,
  output logic [PW_W-1:0]  malu_pw,
  output logic             malu_lhs_sign,
  output logic             malu_rhs_sign,
  output logic             malu_drem_unsigned,
  output logic             malu_carryless,
  output logic             malu_valid,
  output logic             malu_flush,
  input  logic             malu_ready,
  input  logic [XLEN-1:0]  malu_result_1,
  input  logic [XLEN-1:0]  malu_result_0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result_hi,
  output logic [XLEN-1:0]  out_result_lo,
  output logic [TAG_W-1:0] out_tag,
`ifdef XC_MALU_ISSUE_CYCLE_COUNT_EN
  output logic [CNT_W-1:0] out_cycles,
`endif
  output logic             out_err
);

  state_e             state_q, state_d;
  malu_req_t          req_q, req_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [2*XLEN-1:0]  res_q, res_d;
  logic               err_q, err_d;
  logic               accept;
  logic               legal;
`ifdef XC_MALU_ISSUE_CYCLE_COUNT_EN
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   cnt_inc;
`endif

  // Next-state, handshake and capture logic.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    tag_d      = tag_q;
    res_d      = res_q;
    err_d      = err_q;
    malu_flush = 1'b0;
`ifdef XC_MALU_ISSUE_CYCLE_COUNT_EN
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
`endif
    legal    = op_legal(in_op);
    in_ready = !in_kill && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    accept   = in_valid && in_ready;

    case (state_q)
      S_BUSY: begin
        malu_flush = malu_ready || in_kill;
`ifdef XC_MALU_ISSUE_CYCLE_COUNT_EN
        cnt_d = cnt_inc;
`endif
        if (in_kill) begin
          state_d = S_IDLE;
        end else if (malu_ready) begin
          state_d = S_DONE;
          res_d   = {malu_result_1, malu_result_0};
`ifdef XC_MALU_ISSUE_CYCLE_COUNT_EN
          cyc_d   = cnt_inc;
`endif
        end
      end
      S_DONE: begin
        if (in_kill || out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    // Acceptance only happens from IDLE or a draining DONE, so it overrides the above.
    if (accept) begin
      state_d             = legal ? S_BUSY : S_DONE;
      req_d.rs1           = in_rs1;
      req_d.rs2           = in_rs2;
      req_d.rs3           = in_rs3;
      req_d.insn          = in_op;
      req_d.pw            = in_pw;
      req_d.lhs_sign      = in_lhs_sign;
      req_d.rhs_sign      = in_rhs_sign;
      req_d.drem_unsigned = in_drem_unsigned;
      req_d.carryless     = in_carryless && (in_op[OP_MUL] || in_op[OP_PMUL]);
      tag_d               = in_tag;
      res_d               = '0;
      err_d               = !legal;
`ifdef XC_MALU_ISSUE_CYCLE_COUNT_EN
      cnt_d               = '0;
      cyc_d               = '0;
`endif
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
`ifdef XC_MALU_ISSUE_CYCLE_COUNT_EN
      cnt_q   <= '0;
      cyc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      err_q   <= err_d;
`ifdef XC_MALU_ISSUE_CYCLE_COUNT_EN
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
`endif
    end
  end

  assign malu_rs1           = req_q.rs1;
  assign malu_rs2           = req_q.rs2;
  assign malu_rs3           = req_q.rs3;
  assign malu_insn          = req_q.insn;
  assign malu_pw            = req_q.pw;
  assign malu_lhs_sign      = req_q.lhs_sign;
  assign malu_rhs_sign      = req_q.rhs_sign;
  assign malu_drem_unsigned = req_q.drem_unsigned;
  assign malu_carryless     = req_q.carryless;
  assign malu_valid         = (state_q == S_BUSY);
  assign out_valid          = (state_q == S_DONE);
  assign out_result_hi      = res_q[2*XLEN-1:XLEN];
  assign out_result_lo      = res_q[XLEN-1:0];
  assign out_tag            = tag_q;
  assign out_err            = err_q;
`ifdef XC_MALU_ISSUE_CYCLE_COUNT_EN
  assign out_cycles         = cyc_q;
`endif

endmodule

// File: tb/tb_xc_malu_issue.sv
// Scoreboard bench for xc_malu_issue with a behavioural stand-in for xc_malu.
module tb_xc_malu_issue;
  import xc_malu_pkg::*;

  localparam int unsigned TW = 5;

  logic          clock = 1'b0;
  logic          resetn;
  logic          in_valid, in_ready, in_kill;
  logic [31:0]   in_rs1, in_rs2, in_rs3;
  logic [6:0]    in_op;
  logic [4:0]    in_pw;
  logic          in_lhs_sign, in_rhs_sign, in_drem_unsigned, in_carryless;
  logic [TW-1:0] in_tag;
  logic [31:0]   malu_rs1, malu_rs2, malu_rs3;
  logic [6:0]    malu_insn;
  logic [4:0]    malu_pw;
  logic          malu_lhs_sign, malu_rhs_sign, malu_drem_unsigned, malu_carryless;
  logic          malu_valid, malu_flush, malu_ready;
  logic [31:0]   malu_result_1, malu_result_0;
  logic          out_valid, out_ready;
  logic [31:0]   out_result_hi, out_result_lo;
  logic [TW-1:0] out_tag;
  logic          out_err;
`ifdef XC_MALU_ISSUE_CYCLE_COUNT_EN
  logic [15:0]   out_cycles;
`endif

  xc_malu_issue #(.TAG_W(TW)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_kill(in_kill),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
    .in_op(in_op), .in_pw(in_pw),
    .in_lhs_sign(in_lhs_sign), .in_rhs_sign(in_rhs_sign),
    .in_drem_unsigned(in_drem_unsigned), .in_carryless(in_carryless),
    .in_tag(in_tag),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_insn(malu_insn), .malu_pw(malu_pw),
    .malu_lhs_sign(malu_lhs_sign), .malu_rhs_sign(malu_rhs_sign),
    .malu_drem_unsigned(malu_drem_unsigned), .malu_carryless(malu_carryless),
    .malu_valid(malu_valid), .malu_flush(malu_flush), .malu_ready(malu_ready),
    .malu_result_1(malu_result_1), .malu_result_0(malu_result_0),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result_hi(out_result_hi), .out_result_lo(out_result_lo),
    .out_tag(out_tag),
`ifdef XC_MALU_ISSUE_CYCLE_COUNT_EN
    .out_cycles(out_cycles),
`endif
    .out_err(out_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0]   res;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  exp_t          sbq[$];
  int            total = 0;
  int            bad = 0;
  int            flush_cnt = 0;
  int            lat = -1;
  bit            or_mode = 1'b1;
  bit            or_force = 1'b0;
  time           acc_t = 0;
  time           last_pop_t = 0;
  // Fields of the most recently accepted instruction, as the bench issued them.
  logic [31:0]   cur_rs1 = '0, cur_rs2 = '0, cur_rs3 = '0;
  logic [6:0]    cur_op = '0;
  logic [4:0]    cur_pw = '0;
  logic          cur_ls = 1'b0, cur_rs = 1'b0, cur_du = 1'b0, cur_cl = 1'b0, cur_legal = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] clmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r = '0;
    for (int i = 0; i < 32; i++) if (b[i]) r = r ^ ({32'b0, a} << i);
    return r;
  endfunction

  // Functional meaning of each operation, used both by the xc_malu stand-in and the scoreboard.
  function automatic logic [63:0] ref_res(input logic [6:0] op, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] c, input logic ls, input logic rs,
      input logic du, input logic cl);
    longint      x, y;
    int          sa, sb;
    logic [31:0] q, r, lo16, hi16;
    logic [63:0] prod;
    x    = ls ? longint'($signed(a)) : longint'({32'b0, a});
    y    = rs ? longint'($signed(b)) : longint'({32'b0, b});
    prod = {32'b0, a} * {32'b0, b};
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (du) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else begin
      sa = a; sb = b;
      q = 32'(sa / sb); r = 32'(sa % sb);
    end
    lo16 = {16'b0, a[15:0]} * {16'b0, b[15:0]};
    hi16 = {16'b0, a[31:16]} * {16'b0, b[31:16]};
    if      (op == 7'b0000001) return cl ? clmul(a, b) : 64'(x * y);
    else if (op == 7'b0000010) return cl ? clmul(a, b) : {hi16, lo16};
    else if (op == 7'b0000100) return {32'b0, q};
    else if (op == 7'b0001000) return {32'b0, r};
    else if (op == 7'b0010000) return prod + {c, 32'b0};
    else if (op == 7'b0100000) return prod + {32'b0, c};
    else if (op == 7'b1000000) return prod - {32'b0, c};
    return 64'd0;
  endfunction

  // xc_malu stand-in: random latency, answers from whatever the wrapper presents.
  initial begin
    malu_ready = 1'b0; malu_result_1 = '0; malu_result_0 = '0;
    forever begin
      @(posedge clock); #1;
      if (!malu_valid || malu_ready) begin
        malu_ready = 1'b0; lat = -1;
      end else begin
        if (lat < 0) lat = $urandom_range(0, 4);
        if (lat == 0) begin
          {malu_result_1, malu_result_0} = ref_res(malu_insn, malu_rs1, malu_rs2, malu_rs3,
              malu_lhs_sign, malu_rhs_sign, malu_drem_unsigned, malu_carryless);
          malu_ready = 1'b1;
        end else lat--;
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      out_ready = or_mode ? or_force : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: protocol rules every cycle, scoreboard pop on each writeback handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resetn) begin
        chk("exclusive_valid", 64'(malu_valid && out_valid), 64'd0);
        chk("in_ready", 64'(in_ready),
            64'(!in_kill && ((!malu_valid && !out_valid) || (out_valid && out_ready))));
        chk("flush", 64'(malu_flush), 64'(malu_valid && (malu_ready || in_kill)));
        if (malu_flush) flush_cnt++;
        if (malu_valid) begin
          chk("malu_legal_only", 64'(cur_legal), 64'd1);
          chk("malu_rs1", 64'(malu_rs1), 64'(cur_rs1));
          chk("malu_rs2", 64'(malu_rs2), 64'(cur_rs2));
          chk("malu_rs3", 64'(malu_rs3), 64'(cur_rs3));
          chk("malu_insn", 64'(malu_insn), 64'(cur_op));
          chk("malu_pw", 64'(malu_pw), 64'(cur_pw));
          chk("malu_ctl", 64'({malu_lhs_sign, malu_rhs_sign, malu_drem_unsigned, malu_carryless}),
              64'({cur_ls, cur_rs, cur_du, cur_cl}));
        end
        if (out_valid && out_ready) begin
          last_pop_t = $time;
          if (sbq.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
          end else begin
            e = sbq.pop_front();
            chk("out_hi", 64'(out_result_hi), 64'(e.res[63:32]));
            chk("out_lo", 64'(out_result_lo), 64'(e.res[31:0]));
            chk("out_tag", 64'(out_tag), 64'(e.tag));
            chk("out_err", 64'(out_err), 64'(e.err));
          end
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] c, input logic [4:0] pw, input logic ls, input logic rs,
      input logic du, input logic cl, input logic [TW-1:0] tag, input bit expect_out);
    bit   ok = 1'b0;
    logic legal;
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rs3 = c; in_pw = pw;
    in_lhs_sign = ls; in_rhs_sign = rs; in_drem_unsigned = du; in_carryless = cl; in_tag = tag;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("issue_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    legal = ($countones(op) == 1);
    cur_rs1 = a; cur_rs2 = b; cur_rs3 = c; cur_op = op; cur_pw = pw;
    cur_ls = ls; cur_rs = rs; cur_du = du; cur_cl = cl && (op == 7'b0000001 || op == 7'b0000010);
    cur_legal = legal;
    acc_t = $time;
    if (expect_out)
      sbq.push_back('{res: legal ? ref_res(op, a, b, c, ls, rs, du, cur_cl) : 64'd0,
                      tag: tag, err: !legal});
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (out_valid) return;
    end
    chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    or_mode = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (sbq.size() == 0 && !out_valid) break;
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  op;
    logic [31:0] a, b;
    resetn = 1'b0; in_valid = 1'b0; in_kill = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_rs3 = '0; in_op = '0; in_pw = '0; in_tag = '0;
    in_lhs_sign = 1'b0; in_rhs_sign = 1'b0; in_drem_unsigned = 1'b0; in_carryless = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_malu_valid", 64'(malu_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_flush", 64'(malu_flush), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst_regs", 64'({malu_rs1, malu_insn, out_tag}), 64'd0);
    chk("rst_result", {out_result_hi, out_result_lo}, 64'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // Unsigned MUL 7*9, free-running writeback.
    or_mode = 1'b0; flush_cnt = 0;
    issue(7'b0000001, 32'd7, 32'd9, 32'd0, PW_32, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
    wait_out();
    chk("mul_lo", 64'(out_result_lo), 64'd63);
    chk("mul_hi", 64'(out_result_hi), 64'd0);
    chk("mul_flush_once", 64'(flush_cnt), 64'd1);
    drain();

    // Signed REM -7 % 2 with writeback stalled for 5 cycles.
    or_mode = 1'b1; or_force = 1'b0;
    issue(7'b0001000, 32'hFFFF_FFF9, 32'd2, 32'd0, PW_32, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1);
    wait_out();
    repeat (5) begin
      @(negedge clock);
      chk("rem_hold_valid", 64'(out_valid), 64'd1);
      chk("rem_hold_lo", 64'(out_result_lo), 64'hFFFF_FFFF);
      chk("rem_hold_tag", 64'(out_tag), 64'd5);
      chk("rem_hold_in_ready", 64'(in_ready), 64'd0);
      chk("rem_hold_malu_valid", 64'(malu_valid), 64'd0);
    end
    or_force = 1'b1;
    drain();

    // Back-to-back DIV: second accepted on the edge that retires the first.
    or_mode = 1'b1; or_force = 1'b0;
    issue(7'b0000100, 32'd100, 32'd7, 32'd0, PW_32, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1);
    fork
      issue(7'b0000100, 32'd5, 32'd0, 32'd0, PW_32, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b1);
      begin
        wait_out();
        chk("b2b_first_lo", 64'(out_result_lo), 64'd14);
        chk("b2b_hold_in_ready", 64'(in_ready), 64'd0);
        or_force = 1'b1;
      end
    join
    chk("b2b_same_cycle", 64'(acc_t), 64'(last_pop_t));
    drain();

    // Illegal op encoding completes in one cycle with err set.
    or_mode = 1'b1; or_force = 1'b0;
    issue(7'b0000011, 32'd1, 32'd2, 32'd3, PW_32, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1);
    @(negedge clock);
    chk("illegal_latency", 64'(out_valid), 64'd1);
    chk("illegal_err", 64'(out_err), 64'd1);
    chk("illegal_result", {out_result_hi, out_result_lo}, 64'd0);
`ifdef XC_MALU_ISSUE_CYCLE_COUNT_EN
    chk("illegal_cycles", 64'(out_cycles), 64'd0);
`endif
    drain();

    // Kill in BUSY on the same cycle xc_malu answers.
    issue(7'b0000001, 32'd11, 32'd13, 32'd0, PW_32, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 1'b0);
    for (int i = 0; i < 50; i++) begin
      if (malu_valid && malu_ready) break;
      @(negedge clock);
    end
    chk("kill_ready_seen", 64'(malu_valid && malu_ready), 64'd1);
    #1 in_kill = 1'b1;
    #1 chk("kill_flush", 64'(malu_flush), 64'd1);
    chk("kill_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock); #1 in_kill = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("kill_no_malu_valid", 64'(malu_valid), 64'd0);
      chk("kill_no_out_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clock); #1;

    // Kill in DONE drops the held result.
    or_mode = 1'b1; or_force = 1'b0;
    issue(7'b0000001, 32'd2, 32'd2, 32'd0, PW_32, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11, 1'b0);
    wait_out();
    #1 in_kill = 1'b1;
    @(posedge clock); #1 in_kill = 1'b0;
    @(negedge clock);
    chk("kill_done_drop", 64'(out_valid), 64'd0);
    @(posedge clock); #1;

    // Asynchronous reset mid-operation, then a clean MUL 3*5.
    issue(7'b0000001, 32'd6, 32'd7, 32'd0, PW_16, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 1'b0);
    #1 resetn = 1'b0;
    #1;
    chk("arst_malu_valid", 64'(malu_valid), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_flush", 64'(malu_flush), 64'd0);
    chk("arst_regs", 64'({malu_rs1, malu_insn, malu_pw, out_tag, out_err}), 64'd0);
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
    or_mode = 1'b1; or_force = 1'b0;
    issue(7'b0000001, 32'd3, 32'd5, 32'd0, PW_32, 1'b0, 1'b0, 1'b0, 1'b0, 5'd13, 1'b1);
    wait_out();
    chk("post_reset_mul", {out_result_hi, out_result_lo}, 64'd15);
    drain();

    // Randomised traffic across all ops, signedness, carryless and illegal encodings.
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'(1 << $urandom_range(0, 6));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      issue(op, a, b, $urandom, 5'(1 << $urandom_range(0, 4)), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
